// File: rtl/ddr4_cmd_monitor.sv
// DDR4 command-bus monitor: per-rank command decode, per-bank open/row/tRCD
// tracking, minimal protocol checks and saturating activity counters.

module ddr4_cmd_monitor #(
   parameter  int ADDR_WIDTH = 17,
   parameter  int RANKS      = 1,
   parameter  int BG_WIDTH   = 2,
   parameter  int BA_WIDTH   = 2,
   parameter  int TRCD_CK    = 16,
   parameter  int CNT_WIDTH  = 32,
   localparam int RW         = (RANKS > 1) ? $clog2(RANKS) : 1,
   localparam int BW         = BG_WIDTH + BA_WIDTH
) (
   input  logic                  c0_ddr4_ck_t,
   input  logic                  c0_ddr4_reset_n,
   input  logic                  c0_ddr4_cke,
   input  logic [RANKS-1:0]      c0_ddr4_cs_n,
   input  logic                  c0_ddr4_act_n,
   input  logic [ADDR_WIDTH-1:0] c0_ddr4_adr,
   input  logic [BG_WIDTH-1:0]   c0_ddr4_bg,
   input  logic [BA_WIDTH-1:0]   c0_ddr4_ba,
   input  logic                  mon_clr,
   output logic                  mon_cmd_valid,
   output logic [2:0]            mon_cmd,
   output logic [RW-1:0]         mon_rank,
   output logic [BW-1:0]         mon_bank,
   output logic [ADDR_WIDTH-1:0] mon_row,
   output logic                  mon_err_valid,
   output logic [2:0]            mon_err_code,
   output logic                  mon_err_sticky,
   output logic [CNT_WIDTH-1:0]  mon_act_cnt,
   output logic [CNT_WIDTH-1:0]  mon_rd_cnt,
   output logic [CNT_WIDTH-1:0]  mon_wr_cnt
);

   localparam int NB = 1 << BW;
   localparam int TW = (TRCD_CK > 1) ? $clog2(TRCD_CK) : 1;
   localparam int CW = $clog2(RANKS + 1);
   localparam logic [TW-1:0] TRCD_LOAD = TW'(TRCD_CK - 1);

   localparam logic [2:0] CMD_MRS = 3'b000;
   localparam logic [2:0] CMD_REF = 3'b001;
   localparam logic [2:0] CMD_PRE = 3'b010;
   localparam logic [2:0] CMD_ACT = 3'b011;
   localparam logic [2:0] CMD_WR  = 3'b100;
   localparam logic [2:0] CMD_RD  = 3'b101;
   localparam logic [2:0] CMD_ZQC = 3'b110;
   localparam logic [2:0] CMD_NOP = 3'b111;
   localparam logic [2:0] OP_RFU  = 3'b011;

   localparam logic [2:0] ERR_NONE          = 3'd0;
   localparam logic [2:0] ERR_MULTI_CS      = 3'd1;
   localparam logic [2:0] ERR_ACT_OPEN      = 3'd2;
   localparam logic [2:0] ERR_ACCESS_CLOSED = 3'd3;
   localparam logic [2:0] ERR_TRCD          = 3'd4;
   localparam logic [2:0] ERR_REF_OPEN      = 3'd5;
   localparam logic [2:0] ERR_RFU           = 3'd6;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic inc, input logic clr);
      if (clr) begin
         return '0;
      end else if (inc && (cnt != '1)) begin
         return cnt + CNT_WIDTH'(1);
      end else begin
         return cnt;
      end
   endfunction

   logic [CW-1:0]         cs_cnt_s;
   logic [RW-1:0]         cs_rank_s;

   logic                  s1_en_r;
   logic                  s1_multi_r;
   logic                  s1_act_n_r;
   logic                  s1_clr_r;
   logic [RW-1:0]         s1_rank_r;
   logic [ADDR_WIDTH-1:0] s1_adr_r;
   logic [BW-1:0]         s1_bank_r;

   logic [NB-1:0]         open_r [RANKS];
   logic [NB-1:0]         open_s [RANKS];
   logic [ADDR_WIDTH-1:0] row_r  [RANKS][NB];
   logic [ADDR_WIDTH-1:0] row_s  [RANKS][NB];
   logic [TW-1:0]         trcd_r [RANKS][NB];
   logic [TW-1:0]         trcd_s [RANKS][NB];

   logic [2:0]            op_s;
   logic                  cur_open_s;
   logic [ADDR_WIDTH-1:0] cur_row_s;
   logic [TW-1:0]         cur_trcd_s;
   logic [2:0]            cmd_s;
   logic                  cmd_valid_s;
   logic                  err_s;
   logic [2:0]            code_s;
   logic [ADDR_WIDTH-1:0] row_out_s;
   logic [BW-1:0]         bank_out_s;
   logic [RW-1:0]         rank_out_s;
   logic                  act_inc_s;
   logic                  rd_inc_s;
   logic                  wr_inc_s;

   // Count asserted chip selects and pick the selected rank.
   always_comb begin
      cs_cnt_s  = '0;
      cs_rank_s = '0;
      for (int r = 0; r < RANKS; r++) begin
         cs_cnt_s  = cs_cnt_s + CW'(!c0_ddr4_cs_n[r]);
         cs_rank_s = c0_ddr4_cs_n[r] ? cs_rank_s : RW'(r);
      end
   end

   // Command bus capture stage; mon_clr travels with the command it accompanies.
   always_ff @(posedge c0_ddr4_ck_t) begin
      if (!c0_ddr4_reset_n) begin
         s1_en_r    <= 1'b0;
         s1_multi_r <= 1'b0;
         s1_act_n_r <= 1'b1;
         s1_clr_r   <= 1'b0;
         s1_rank_r  <= '0;
         s1_adr_r   <= '0;
         s1_bank_r  <= '0;
      end else begin
         s1_en_r    <= c0_ddr4_cke && (cs_cnt_s != '0);
         s1_multi_r <= c0_ddr4_cke && (cs_cnt_s > CW'(1));
         s1_act_n_r <= c0_ddr4_act_n;
         s1_clr_r   <= mon_clr;
         s1_rank_r  <= cs_rank_s;
         s1_adr_r   <= c0_ddr4_adr;
         s1_bank_r  <= {c0_ddr4_bg, c0_ddr4_ba};
      end
   end

   // Decode, protocol checks and next bank state.
   always_comb begin
      open_s = open_r;
      row_s  = row_r;
      for (int r = 0; r < RANKS; r++) begin
         for (int b = 0; b < NB; b++) begin
            trcd_s[r][b] = (trcd_r[r][b] != '0) ? (trcd_r[r][b] - TW'(1)) : '0;
         end
      end
      op_s        = s1_adr_r[16:14];
      cur_open_s  = open_r[s1_rank_r][s1_bank_r];
      cur_row_s   = row_r[s1_rank_r][s1_bank_r];
      cur_trcd_s  = trcd_r[s1_rank_r][s1_bank_r];
      cmd_s       = CMD_NOP;
      cmd_valid_s = 1'b0;
      err_s       = 1'b0;
      code_s      = ERR_NONE;
      row_out_s   = '0;
      bank_out_s  = '0;
      rank_out_s  = '0;
      act_inc_s   = 1'b0;
      rd_inc_s    = 1'b0;
      wr_inc_s    = 1'b0;

      if (!s1_en_r) begin
         cmd_s = CMD_NOP;
      end else if (s1_multi_r) begin
         err_s  = 1'b1;
         code_s = ERR_MULTI_CS;
      end else if (!s1_act_n_r) begin
         cmd_s       = CMD_ACT;
         cmd_valid_s = 1'b1;
         rank_out_s  = s1_rank_r;
         bank_out_s  = s1_bank_r;
         row_out_s   = s1_adr_r;
         act_inc_s   = 1'b1;
         err_s       = cur_open_s;
         code_s      = cur_open_s ? ERR_ACT_OPEN : ERR_NONE;
         open_s[s1_rank_r][s1_bank_r] = 1'b1;
         row_s[s1_rank_r][s1_bank_r]  = s1_adr_r;
         trcd_s[s1_rank_r][s1_bank_r] = TRCD_LOAD;
      end else begin
         case (op_s)
            CMD_MRS, CMD_ZQC: begin
               cmd_s       = op_s;
               cmd_valid_s = 1'b1;
               rank_out_s  = s1_rank_r;
               bank_out_s  = s1_bank_r;
            end
            CMD_REF: begin
               cmd_s       = CMD_REF;
               cmd_valid_s = 1'b1;
               rank_out_s  = s1_rank_r;
               bank_out_s  = s1_bank_r;
               err_s       = |open_r[s1_rank_r];
               code_s      = (|open_r[s1_rank_r]) ? ERR_REF_OPEN : ERR_NONE;
            end
            CMD_PRE: begin
               cmd_s       = CMD_PRE;
               cmd_valid_s = 1'b1;
               rank_out_s  = s1_rank_r;
               bank_out_s  = s1_bank_r;
               if (s1_adr_r[10]) begin
                  open_s[s1_rank_r] = '0;
               end else begin
                  open_s[s1_rank_r][s1_bank_r] = 1'b0;
               end
            end
            CMD_WR, CMD_RD: begin
               cmd_s       = op_s;
               cmd_valid_s = 1'b1;
               rank_out_s  = s1_rank_r;
               bank_out_s  = s1_bank_r;
               row_out_s   = cur_open_s ? cur_row_s : '0;
               if (!cur_open_s) begin
                  err_s  = 1'b1;
                  code_s = ERR_ACCESS_CLOSED;
               end else if (cur_trcd_s != '0) begin
                  err_s  = 1'b1;
                  code_s = ERR_TRCD;
               end else begin
                  err_s  = 1'b0;
                  code_s = ERR_NONE;
               end
               // Auto-precharge closes the bank only after the access was checked.
               open_s[s1_rank_r][s1_bank_r] = cur_open_s && !s1_adr_r[10];
               wr_inc_s = (op_s == CMD_WR);
               rd_inc_s = (op_s == CMD_RD);
            end
            OP_RFU: begin
               err_s  = 1'b1;
               code_s = ERR_RFU;
            end
            default: begin
               cmd_s = CMD_NOP;
            end
         endcase
      end
   end

   // Bank state, counters and registered monitor outputs.
   always_ff @(posedge c0_ddr4_ck_t) begin
      if (!c0_ddr4_reset_n) begin
         for (int r = 0; r < RANKS; r++) begin
            open_r[r] <= '0;
            for (int b = 0; b < NB; b++) begin
               row_r[r][b]  <= '0;
               trcd_r[r][b] <= '0;
            end
         end
         mon_cmd_valid  <= 1'b0;
         mon_cmd        <= CMD_NOP;
         mon_rank       <= '0;
         mon_bank       <= '0;
         mon_row        <= '0;
         mon_err_valid  <= 1'b0;
         mon_err_code   <= ERR_NONE;
         mon_err_sticky <= 1'b0;
         mon_act_cnt    <= '0;
         mon_rd_cnt     <= '0;
         mon_wr_cnt     <= '0;
      end else begin
         open_r         <= open_s;
         row_r          <= row_s;
         trcd_r         <= trcd_s;
         mon_cmd_valid  <= cmd_valid_s;
         mon_cmd        <= cmd_s;
         mon_rank       <= rank_out_s;
         mon_bank       <= bank_out_s;
         mon_row        <= row_out_s;
         mon_err_valid  <= err_s;
         mon_err_code   <= code_s;
         mon_err_sticky <= s1_clr_r ? 1'b0 : (mon_err_sticky | err_s);
         mon_act_cnt    <= sat_inc(mon_act_cnt, act_inc_s, s1_clr_r);
         mon_rd_cnt     <= sat_inc(mon_rd_cnt, rd_inc_s, s1_clr_r);
         mon_wr_cnt     <= sat_inc(mon_wr_cnt, wr_inc_s, s1_clr_r);
      end
   end

endmodule
